// File: rtl/sram_bus_if.sv
// CPU-side SRAM bus: active-low strobes, word address, and the responder's Ready/Busy.
// The shared I_O data bus stays a plain inout on the responder.
interface sram_bus_if;
  logic [15:0] A;
  logic        CE;
  logic        UB;
  logic        LB;
  logic        OE;
  logic        WE;
  logic        Ready;
  logic        Busy;

  modport master (output A, CE, UB, LB, OE, WE, input Ready, Busy);
  modport slave  (input A, CE, UB, LB, OE, WE, output Ready, Busy);
endinterface

// File: rtl/sram_responder.sv
// Memory-side responder for the active-low SRAM bus with programmable wait states.
// States: IDLE wait for request | WAIT count wait states | ACCESS commit/fetch, Ready | HOLD drive read data
module sram_responder #(
  parameter int MEM_AW      = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic       Clk,
  input  logic       Reset,
  sram_bus_if.slave  bus,
  inout  wire [15:0] I_O
);

  localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_HOLD} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [MEM_AW-1:0]   addr_q, addr_d;
  logic                ub_sel_q, ub_sel_d;
  logic                lb_sel_q, lb_sel_d;
  logic                wr_q, wr_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic [15:0]         rd_q, rd_d;
  logic                mem_we_hi, mem_we_lo;
  logic                req_valid;
  logic                drv;
  logic                unused_a;

  logic [15:0] mem [2**MEM_AW];

  assign req_valid = ~bus.CE & (~bus.OE | ~bus.WE);
  assign unused_a  = ^bus.A[15:MEM_AW];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    ub_sel_d = ub_sel_q;
    lb_sel_d = lb_sel_q;
    wr_d     = wr_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d   = bus.A[MEM_AW-1:0];
          ub_sel_d = ~bus.UB;
          lb_sel_d = ~bus.LB;
          wr_d     = ~bus.WE;
          cnt_d    = CNT_INIT;
          if (WAIT_STATES > 0) state_d = S_WAIT;
          else                 state_d = S_ACCESS;
        end
      end
      S_WAIT: begin
        if (bus.CE)              state_d = S_IDLE;
        else if (cnt_q == '0)    state_d = S_ACCESS;
        else                     cnt_d   = cnt_q - CW'(1);
      end
      S_ACCESS: begin
        // lane selects are re-sampled here; HOLD drives only these lanes
        ub_sel_d = ~bus.UB;
        lb_sel_d = ~bus.LB;
        state_d  = S_HOLD;
      end
      S_HOLD: begin
        if (bus.CE || (wr_q ? bus.WE : bus.OE)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_ACCESS);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      ub_sel_q <= 1'b0;
      lb_sel_q <= 1'b0;
      wr_q     <= 1'b0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      ub_sel_q <= ub_sel_d;
      lb_sel_q <= lb_sel_d;
      wr_q     <= wr_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

  // Array and read register are not reset; reset forces IDLE, which blocks the write enables.
  always_comb begin
    mem_we_hi = (state_q == S_ACCESS) & wr_q & ~bus.UB;
    mem_we_lo = (state_q == S_ACCESS) & wr_q & ~bus.LB;
    rd_d      = rd_q;
    if (state_q == S_ACCESS && !wr_q) rd_d = mem[addr_q];
  end

  always_ff @(posedge Clk) begin
    if (mem_we_hi) mem[addr_q][15:8] <= I_O[15:8];
    if (mem_we_lo) mem[addr_q][7:0]  <= I_O[7:0];
    rd_q <= rd_d;
  end

  assign drv = (state_q == S_HOLD) & ~wr_q & ~bus.CE & ~bus.OE & bus.WE;

  assign I_O[15:8] = (drv & ub_sel_q) ? rd_q[15:8] : 8'hzz;
  assign I_O[7:0]  = (drv & lb_sel_q) ? rd_q[7:0]  : 8'hzz;

  assign bus.Ready = ready_q;
  assign bus.Busy  = busy_q;

endmodule
